// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the LSU / instruction fetch
// and the single-ported 8-bit RAM/IO bus. Arbitrates the two requesters
// round-robin, splits 1/2/4-byte accesses into byte cycles and assembles read
// data little-endian.
// Optional feature macro: MEM_CTRL_IO_STALL_EN -- hold write byte cycles to the
// UART addresses (0x00030000 / 0x00030004) while io_buffer_full is high.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  // load/store unit
  input  logic        enable_from_lsu,
  input  logic        read_write_flag_from_lsu,
  input  logic [31:0] address_from_lsu,
  input  logic [31:0] data_from_lsu,
  input  logic [1:0]  width_from_lsu,
  output logic        end_to_lsu,
  output logic [31:0] data_to_lsu,
  output logic        available_to_lsu,
  // instruction fetch
  input  logic        enable_from_ifetch,
  input  logic [31:0] address_from_ifetch,
  output logic        end_to_ifetch,
  output logic [31:0] inst_to_ifetch,
  // reorder buffer flush
  input  logic        rollback_flag_from_rob,
  // RAM/IO bus
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_LAST   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state, state_nxt;

  // latched transaction
  logic [31:0]     base_addr;
  logic            is_read;
  logic            is_fetch;
  logic [2:0]      len;
  logic [2:0]      cnt;
  logic [3:0][7:0] wdata_b;
  logic [3:0][7:0] rdata_b;

  // round-robin pointer: 1 = fetch was granted last, so LSU wins a tie
  logic            last_fetch;

  logic            lsu_req, if_req;
  logic            grant_lsu, grant_if;
  logic [31:0]     cur_addr;
  logic [7:0]      wbyte;
  logic            last_byte;
  logic            fetch_kill;
  logic            stall;
  logic [2:0]      lsu_len;

  // A fetch is never granted while a flush is being signalled.
  assign lsu_req    = enable_from_lsu;
  assign if_req     = enable_from_ifetch & ~rollback_flag_from_rob;
  assign grant_lsu  = lsu_req & (~if_req | last_fetch);
  assign grant_if   = if_req & ~grant_lsu;

  assign cur_addr   = base_addr + {29'd0, cnt};
  assign wbyte      = wdata_b[cnt[1:0]];
  assign last_byte  = (cnt == (len - 3'd1));
  assign fetch_kill = is_fetch & rollback_flag_from_rob;

  assign lsu_len    = (width_from_lsu == 2'b00) ? 3'd1 :
                      (width_from_lsu == 2'b01) ? 3'd2 : 3'd4;

`ifdef MEM_CTRL_IO_STALL_EN
  // UART writes wait in place until the output buffer has room.
  assign stall = (state == S_ACCESS) & ~is_read & io_buffer_full &
                 ((cur_addr == 32'h0003_0000) | (cur_addr == 32'h0003_0004));
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign stall          = 1'b0;
`endif

  // State register; rdy_in low freezes the machine.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state <= S_IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  // Next-state and bus/completion outputs.
  always_comb begin
    state_nxt        = state;
    mem_a            = '0;
    mem_wr           = 1'b0;
    mem_dout         = '0;
    end_to_lsu       = 1'b0;
    end_to_ifetch    = 1'b0;
    data_to_lsu      = '0;
    inst_to_ifetch   = '0;
    available_to_lsu = 1'b0;
    case (state)
      S_IDLE: begin
        available_to_lsu = 1'b1;
        if (grant_lsu | grant_if) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        mem_a    = cur_addr;
        mem_wr   = ~is_read & ~stall;
        mem_dout = wbyte;
        if (fetch_kill)              state_nxt = S_IDLE;
        else if (!stall && last_byte) state_nxt = is_read ? S_LAST : S_DONE;
      end
      S_LAST: begin
        state_nxt = fetch_kill ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        if (is_fetch) begin
          // a flush arriving in the pulse cycle squashes the fetch result
          end_to_ifetch  = ~rollback_flag_from_rob;
          inst_to_ifetch = rollback_flag_from_rob ? 32'd0 : rdata_b;
        end else begin
          end_to_lsu  = 1'b1;
          data_to_lsu = rdata_b;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transaction latch, byte counter and read-data assembly.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      base_addr  <= '0;
      is_read    <= 1'b0;
      is_fetch   <= 1'b0;
      len        <= 3'd1;
      cnt        <= '0;
      wdata_b    <= '0;
      rdata_b    <= '0;
      last_fetch <= 1'b1;
    end else if (rdy_in) begin
      case (state)
        S_IDLE: begin
          if (grant_lsu | grant_if) begin
            base_addr  <= grant_lsu ? address_from_lsu : address_from_ifetch;
            is_read    <= grant_lsu ? read_write_flag_from_lsu : 1'b1;
            is_fetch   <= grant_if;
            len        <= grant_lsu ? lsu_len : 3'd4;
            wdata_b    <= (grant_lsu & ~read_write_flag_from_lsu) ? data_from_lsu : 32'd0;
            rdata_b    <= '0;
            cnt        <= '0;
            last_fetch <= grant_if;
          end
        end
        S_ACCESS: begin
          // RAM answers one cycle after the address, so byte k-1 lands now
          if (is_read && cnt != 3'd0) rdata_b[cnt[1:0] - 2'd1] <= mem_din;
          if (!stall) cnt <= cnt + 3'd1;
        end
        S_LAST: begin
          rdata_b[cnt[1:0] - 2'd1] <= mem_din;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the load/store unit and the instruction-fetch unit on one side and the single-ported 8-bit RAM/IO bus on the other. It arbitrates between the two requesters and splits each 1/2/4-byte access into consecutive byte cycles. Read bytes are assembled little-endian and returned with a one-cycle completion pulse. It is the block directly downstream of the LSU, consuming its enable/read-write/address/data request.

## Interface
- No parameters.
- clk_in  input  1  clock, all state on rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; low freezes all state and outputs
- enable_from_lsu  input  1  LSU request, held until end_to_lsu
- read_write_flag_from_lsu  input  1  1 read, 0 write
- address_from_lsu  input  32  byte address
- data_from_lsu  input  32  store data, low bytes used
- width_from_lsu  input  2  00 byte, 01 half, 10/11 word
- end_to_lsu  output  1  one-cycle completion pulse
- data_to_lsu  output  32  zero-extended read data, valid with end_to_lsu
- available_to_lsu  output  1  high when controller is IDLE
- enable_from_ifetch  input  1  fetch request (always 4 bytes, read)
- address_from_ifetch  input  32  fetch address
- end_to_ifetch  output  1  one-cycle completion pulse
- inst_to_ifetch  output  32  fetched word, valid with end_to_ifetch
- rollback_flag_from_rob  input  1  flush; aborts an in-flight fetch
- mem_din  input  8  RAM read byte, one cycle after mem_a
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 write, 0 read
- io_buffer_full  input  1  UART output buffer full

## Operation
- States: IDLE, ACCESS, LAST (read final-capture), DONE.
- IDLE: samples requests. LSU and fetch both pending: grant goes to the one not granted last (round-robin pointer; reset points at fetch, so LSU wins first). Only one pending: it is granted. A fetch request is not granted in a cycle with rollback_flag_from_rob high.
- On grant: address, rw flag, length N (1/2/4) and store data are latched, byte counter k=0, go to ACCESS.
- ACCESS: drive mem_a=base+k, mem_wr=~rw, mem_dout=byte k of store data; k increments each cycle. Reads capture mem_din into byte k-1 when k≥1. After byte N-1: writes go to DONE, reads go to LAST.
- LAST: captures final byte, mem_a=0, mem_wr=0, then DONE.
- DONE: pulse end_to_lsu or end_to_ifetch for one cycle with the assembled data; no request sampled; then IDLE.
- Rollback during a fetch transaction (ACCESS/LAST/DONE-before-pulse): return to IDLE next edge, end_to_ifetch stays low. LSU transactions ignore rollback (stores must complete; the LSU discards squashed loads).
- Address arithmetic is 32-bit wrapping; 0xFFFFFFFF + 1 = 0.
- Outside ACCESS: mem_a=0, mem_wr=0, mem_dout=0.

## Timing
- Cycle 0 = cycle a request is sampled in IDLE. Byte i (0-based) is driven in cycle i+1.
- Read of N bytes: end pulse in cycle N+2 (LW: cycle 6). Write of N bytes: end pulse in cycle N+1.
- Next request is sampled earliest in the cycle after the end pulse.
- Reset (asynchronous, rst_in low): state IDLE, all outputs 0 except available_to_lsu=1 after release; data_to_lsu=0, inst_to_ifetch=0. Reset mid-transaction abandons it with no end pulse.
- rdy_in low: no state, counter or output changes; a pending write byte remains on the bus.

## Configuration
- MEM_CTRL_IO_STALL_EN defined: a write byte cycle to address 0x00030000 or 0x00030004 is held (k not advanced, mem_wr forced 0) while io_buffer_full is high. The byte is issued in the first cycle io_buffer_full is low, and end timing shifts by the stall count.
- Undefined: io_buffer_full is ignored; IO writes follow normal timing.

## Test plan
- LW 0x1000, RAM bytes 11 22 33 44 -> mem_a 0x1000..0x1003 in cycles 1–4, end_to_lsu in cycle 6, data_to_lsu=0x44332211.
- SB 0x2003, data 0x123456AB -> one cycle mem_wr=1, mem_a=0x2003, mem_dout=0xAB; end_to_lsu in cycle 2.
- LSU and fetch both requesting from reset -> LSU served first, fetch granted in the cycle after the LSU end pulse, fetch returns 0x00000013 from bytes 13 00 00 00.
- Rollback in cycle 2 of a fetch -> IDLE next edge, no end_to_ifetch; a concurrent LSU request is then granted.
- rst_in low during cycle 2 of SW -> mem_wr=0 immediately, no end_to_lsu, available_to_lsu=1 after release.
- MEM_CTRL_IO_STALL_EN defined, SB to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr asserted in cycle 4, end_to_lsu in cycle 5.
